fpga_soc_reset_sequencer: RTL and testbench

- Sits directly downstream of the 100 MHz fabric clock conditioning circuit (FCCC) and is clocked by its GL0 output.
- Consumes the asynchronous PLL LOCK indication and turns it into staged, glitch-free reset releases for the fabric domains: bus/interconnect first, then peripherals, then payload logic.
- Re-asserts every reset when lock is lost or software requests it.
- Counts lock-loss events for housekeeping telemetry.

---
 rtl/fpga_soc_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_fpga_soc_reset_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fpga_soc_reset_sequencer.sv
// Staged reset release for fabric domains, driven by a synchronized PLL lock.
// Bus/interconnect (bit 0) comes out of reset first; any lock loss re-asserts every domain together.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | all resets held, waiting for synchronized lock
// STABLE    | lock seen, timing the stability window
// RELEASE   | releasing resets one stage per gap, ascending order
// RUN       | all stages released, READY high
// SW_HOLD   | software-requested reset, all stages held for one gap
module fpga_soc_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pll_lock_i,
  input  logic                  sw_reset_req_i,
  output logic [NUM_STAGES-1:0] rst_n_out_o,
  output logic                  ready_o,
  output logic [7:0]            lock_loss_cnt_o,
  output logic [2:0]            state_o
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_STABLE    = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_SW_HOLD   = 3'd4;

  localparam logic [CNT_WIDTH-1:0]  STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LAST    = CNT_WIDTH'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [NUM_STAGES-1:0] STAGE0      = NUM_STAGES'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic [NUM_STAGES-1:0]  rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             llc_q, llc_d;
  logic                   lose;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Only a loss after at least one stage was released counts as telemetry.
  assign lose = !lock_s &&
                (state_q == ST_RELEASE || state_q == ST_RUN || state_q == ST_SW_HOLD);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    llc_d   = llc_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        rst_d   = '0;
        ready_d = 1'b0;
        timer_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          timer_d = '0;
          rst_d   = STAGE0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (rst_q[NUM_STAGES-1]) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            rst_d = (rst_q << 1) | STAGE0;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (sw_reset_req_i) begin
          state_d = ST_SW_HOLD;
          rst_d   = '0;
          ready_d = 1'b0;
          timer_d = '0;
        end
      end
      ST_SW_HOLD: begin
        if (timer_q == GAP_LAST) begin
          state_d = ST_RELEASE;
          timer_d = '0;
          rst_d   = STAGE0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        timer_d = '0;
        rst_d   = '0;
        ready_d = 1'b0;
      end
    endcase

    // Lock loss overrides a software request and any timer expiry in the same cycle.
    if (lose) begin
      state_d = ST_WAIT_LOCK;
      timer_d = '0;
      rst_d   = '0;
      ready_d = 1'b0;
      llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      state_q <= ST_WAIT_LOCK;
      timer_q <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      llc_q   <= 8'd0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      llc_q   <= llc_d;
    end
  end

  assign rst_n_out_o     = rst_q;
  assign ready_o         = ready_q;
  assign lock_loss_cnt_o = llc_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fpga_soc_reset_sequencer.sv
// Directed plus randomized bench for the reset sequencer, compared against a
// timestamp-based reference model of the release schedule.
module tb_fpga_soc_reset_sequencer;
  localparam int LSC = 8;
  localparam int GAP = 4;
  localparam int NS  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          sw_req;
  logic [NS-1:0] rst_n_out;
  logic          ready;
  logic [7:0]    llc;
  logic [2:0]    state;

  fpga_soc_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(LSC), .NUM_STAGES(NS),
    .STAGE_GAP_CYCLES(GAP), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pll_lock_i(pll_lock), .sw_reset_req_i(sw_req),
    .rst_n_out_o(rst_n_out), .ready_o(ready), .lock_loss_cnt_o(llc), .state_o(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lock history delayed by the synchronizer, a run-length of
  // consecutive lock samples, and the edge at which stage 0 is (re)released.
  int cyc = 0;
  bit m_rel;
  int m_trel;
  int m_run;
  int m_llc;
  bit h0, h1;

  task automatic model_reset();
    m_rel = 0; m_trel = 0; m_run = 0; m_llc = 0; h0 = 0; h1 = 0;
  endtask

  task automatic model_step(input bit pll, input bit sw);
    bit ls;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      ls = h1; h1 = h0; h0 = pll;
      if (!m_rel) begin
        if (ls) begin
          m_run++;
          if (m_run == LSC + 1) begin m_rel = 1; m_trel = cyc; end
        end else m_run = 0;
      end else if (!ls) begin
        m_rel = 0; m_run = 0;
        if (m_llc < 255) m_llc++;
      end else if (sw && cyc > m_trel + NS*GAP) begin
        m_trel = cyc + GAP;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [NS-1:0] e_rst;
    logic          e_rdy;
    logic [2:0]    e_st;
    for (int k = 0; k < NS; k++) e_rst[k] = m_rel && (cyc >= m_trel + k*GAP);
    e_rdy = m_rel && (cyc >= m_trel + NS*GAP);
    if (!m_rel)                     e_st = (m_run == 0) ? 3'd0 : 3'd1;
    else if (cyc < m_trel)          e_st = 3'd4;
    else if (cyc < m_trel + NS*GAP) e_st = 3'd2;
    else                            e_st = 3'd3;
    check_eq("rst_n_out", 32'(rst_n_out), 32'(e_rst));
    check_eq("ready", 32'(ready), 32'(e_rdy));
    check_eq("lock_loss_cnt", 32'(llc), 32'(m_llc));
    check_eq("state", 32'(state), 32'(e_st));
  endtask

  // Entered and left at a falling edge; inputs change away from the active edge.
  task automatic tick(input bit pll, input bit sw);
    pll_lock = pll;
    sw_req   = sw;
    @(posedge clk);
    model_step(pll, sw);
    @(negedge clk);
    check_outputs();
  endtask

  // Holds lock high from a non-locked condition and measures release latencies.
  task automatic relock(input string tag);
    int t0, lat0, latr;
    bit seen0;
    t0 = cyc + 1; lat0 = -1; latr = -1; seen0 = 0;
    for (int i = 0; i < 60 && latr < 0; i++) begin
      tick(1, 0);
      if (!seen0 && rst_n_out[0] === 1'b1) begin seen0 = 1; lat0 = cyc - t0; end
      if (ready === 1'b1) latr = cyc - t0;
    end
    check_eq({tag, "_rst0_latency"}, 32'(lat0), 32'(LSC + 2));
    check_eq({tag, "_ready_latency"}, 32'(latr), 32'(LSC + 2 + NS*GAP));
  endtask

  initial begin
    int t0, lat0, latr, n;
    bit found;
    rst_n = 1'b0; pll_lock = 1'b0; sw_req = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (5) tick(0, 0);
    rst_n = 1'b1;
    repeat (10) tick(0, 0);
    tick(0, 1); tick(0, 0); tick(0, 1); tick(0, 0);
    check_eq("sw_in_wait_state", 32'(state), 32'd0);

    relock("powerup");
    check_eq("powerup_llc", 32'(llc), 32'd0);
    repeat (5) tick(1, 0);

    // Lock loss in RUN: outputs drop one cycle after lock_s falls.
    tick(0, 0); tick(0, 0);
    check_eq("run_loss_pre", 32'(rst_n_out), 32'h7);
    tick(0, 0);
    check_eq("run_loss_rst", 32'(rst_n_out), 32'h0);
    check_eq("run_loss_llc", 32'(llc), 32'd1);
    repeat (3) tick(0, 0);

    // Glitch inside the stability window: 5 stable samples, then 3 low.
    repeat (7) tick(1, 0);
    repeat (3) tick(0, 0);
    check_eq("glitch_state", 32'(state), 32'd0);
    check_eq("glitch_llc", 32'(llc), 32'd1);
    relock("after_glitch");
    repeat (3) tick(1, 0);

    // Software reset in RUN.
    t0 = cyc + 1; lat0 = -1; latr = -1;
    tick(1, 1);
    check_eq("sw_hold_rst", 32'(rst_n_out), 32'h0);
    for (int i = 0; i < 40 && latr < 0; i++) begin
      tick(1, 0);
      if (lat0 < 0 && rst_n_out[0] === 1'b1) lat0 = cyc - t0;
      if (ready === 1'b1) latr = cyc - t0;
    end
    check_eq("sw_rst0_latency", 32'(lat0), 32'(GAP));
    check_eq("sw_ready_latency", 32'(latr), 32'(GAP + NS*GAP));
    repeat (2) tick(1, 0);

    // Software request and lock_s fall on the same RUN edge.
    tick(0, 0); tick(0, 0); tick(0, 1);
    check_eq("simul_state", 32'(state), 32'd0);
    check_eq("simul_llc", 32'(llc), 32'd2);
    tick(0, 0);
    relock("after_simul");

    repeat (60) begin
      n = $urandom_range(1, 40);
      repeat (n) tick(1, $urandom_range(0, 9) == 0);
      n = $urandom_range(1, 5);
      repeat (n) tick(0, $urandom_range(0, 3) == 0);
    end

    repeat (260) begin
      n = $urandom_range(11, 20);
      repeat (n) tick(1, 0);
      n = $urandom_range(1, 3);
      repeat (n) tick(0, 0);
    end
    repeat (3) tick(0, 0);
    check_eq("llc_saturated", 32'(llc), 32'd255);

    // Asynchronous reset in the middle of RELEASE.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1, 0);
      if (m_rel && cyc >= m_trel + GAP && cyc < m_trel + 2*GAP) found = 1;
    end
    check_eq("reach_release", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", 32'(rst_n_out), 32'h0);
    check_eq("async_llc", 32'(llc), 32'd0);
    check_eq("async_ready", 32'(ready), 32'd0);
    check_eq("async_state", 32'(state), 32'd0);
    @(negedge clk);
    model_reset();
    repeat (3) tick(1, 0);
    rst_n = 1'b1;
    relock("post_reset");
    check_eq("post_reset_llc", 32'(llc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
